// File: rtl/instruction_mem.sv
// rtl/instruction_mem.sv - word-addressed instruction memory with registered fetch output
// Optional runtime programming port enabled by INSTRUCTION_MEM_PROG_PORT_EN.
module instruction_mem #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = $clog2(DEPTH),
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] PC,
`ifdef INSTRUCTION_MEM_PROG_PORT_EN
  input  logic        prog_we,
  input  logic [15:0] prog_addr,
  input  logic [15:0] prog_data,
`endif
  output logic [15:0] INSTR
);

  logic [15:0] instr_q;
  logic [15:0] instr_d;
  logic        pc_in_range;

  // Any address bit at or above ADDR_W means out of range; no wrap-around.
  assign pc_in_range = ((PC >> ADDR_W) == 16'd0);

`ifdef INSTRUCTION_MEM_PROG_PORT_EN
  logic [15:0] mem_q [DEPTH] = '{
    0: 16'h0000, 1: 16'h2101, 2: 16'h2202, 3: 16'h0123, 4: 16'h1234,
    5: 16'h4345, 6: 16'h6456, 7: 16'h8567, 8: 16'hF000,
    default: 16'h0000
  };
  logic prog_in_range;

  assign prog_in_range = ((prog_addr >> ADDR_W) == 16'd0);

  // Reset only gates writes; it never clears the array.
  always_ff @(posedge clk) begin
    if (rst_n && prog_we && prog_in_range) begin
      mem_q[prog_addr[ADDR_W-1:0]] <= prog_data;
    end
  end

  always_comb begin
    instr_d = NOP_WORD;
    if (pc_in_range) begin
      instr_d = mem_q[PC[ADDR_W-1:0]];
    end
  end
`else
  function automatic logic [15:0] rom_word(input logic [ADDR_W-1:0] addr);
    case (32'(addr))
      1:       rom_word = 16'h2101;
      2:       rom_word = 16'h2202;
      3:       rom_word = 16'h0123;
      4:       rom_word = 16'h1234;
      5:       rom_word = 16'h4345;
      6:       rom_word = 16'h6456;
      7:       rom_word = 16'h8567;
      8:       rom_word = 16'hF000;
      default: rom_word = 16'h0000;
    endcase
  endfunction

  always_comb begin
    instr_d = NOP_WORD;
    if (pc_in_range) begin
      instr_d = rom_word(PC[ADDR_W-1:0]);
    end
  end
`endif

  // Non-blocking update gives read-before-write against a same-edge program write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
    end else begin
      instr_q <= instr_d;
    end
  end

  assign INSTR = instr_q;

endmodule

// File: tb/tb_instruction_mem.sv
// tb/tb_instruction_mem.sv - scoreboard bench for instruction_mem (INSTRUCTION_MEM_PROG_PORT_EN optional)
module tb_instruction_mem;

  logic        clk;
  logic        rst_n;
  logic [15:0] PC;
  logic [15:0] INSTR;
`ifdef INSTRUCTION_MEM_PROG_PORT_EN
  logic        prog_we;
  logic [15:0] prog_addr;
  logic [15:0] prog_data;
`endif

  int errors;
  int checks;
  logic [15:0] sb_q[$];

  instruction_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PC        (PC),
`ifdef INSTRUCTION_MEM_PROG_PORT_EN
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
`endif
    .INSTR     (INSTR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] exp;
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check_eq(tag, INSTR, exp);
    end
  endtask

  // Compare the previous fetch, then present a new PC and queue its expected word.
  task automatic fetch(input logic [15:0] pc, input logic [15:0] exp, input string tag);
    @(negedge clk);
    pop_check(tag);
    PC = pc;
`ifdef INSTRUCTION_MEM_PROG_PORT_EN
    prog_we = 1'b0;
`endif
    sb_q.push_back(exp);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    pop_check(tag);
  endtask

  initial begin
    logic [15:0] seq_exp [1:8];
    errors = 0;
    checks = 0;
    seq_exp = '{16'h2101, 16'h2202, 16'h0123, 16'h1234,
                16'h4345, 16'h6456, 16'h8567, 16'hF000};
`ifdef INSTRUCTION_MEM_PROG_PORT_EN
    prog_we   = 1'b0;
    prog_addr = 16'h0000;
    prog_data = 16'h0000;
`endif
    PC    = 16'd5;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_eq("reset_async", INSTR, 16'h0000);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("reset_hold", INSTR, 16'h0000);
    end
    rst_n = 1'b1;
    sb_q.push_back(16'h4345);

    for (int i = 1; i <= 8; i++) begin
      fetch(16'(i), seq_exp[i], "seq");
    end
    fetch(16'd9,    16'h0000, "seq_last");
    fetch(16'h0100, 16'h0000, "unprog9");
    fetch(16'hFFFF, 16'h0000, "pc_depth");
    fetch(16'h0101, 16'h0000, "pc_ffff");
    fetch(16'h0108, 16'h0000, "alias_101");
    fetch(16'd1,    16'h2101, "alias_108");
    fetch(16'd2,    16'h2202, "restart");
    drain("pre_rst");

    // Mid-stream reset dropped between edges.
    PC = 16'd3;
    #2 rst_n = 1'b0;
    #1 check_eq("midrst_async", INSTR, 16'h0000);
    @(negedge clk);
    check_eq("midrst_hold", INSTR, 16'h0000);
    rst_n = 1'b1;
    sb_q.push_back(16'h0123);
    fetch(16'd4, 16'h1234, "resume");

`ifdef INSTRUCTION_MEM_PROG_PORT_EN
    @(negedge clk);
    pop_check("resume_next");
    PC        = 16'd4;
    prog_we   = 1'b1;
    prog_addr = 16'd4;
    prog_data = 16'hBEEF;
    sb_q.push_back(16'h1234);
    fetch(16'd4, 16'hBEEF, "rbw_old");
    @(negedge clk);
    pop_check("rbw_new");
    PC        = 16'd0;
    prog_we   = 1'b1;
    prog_addr = 16'h0100;
    prog_data = 16'hDEAD;
    sb_q.push_back(16'h0000);
    fetch(16'd0, 16'h0000, "oob_wr");
    fetch(16'd4, 16'hBEEF, "oob_alias0");
    fetch(16'h00FF, 16'h0000, "oob_keep4");
    drain("oob_ff");
`else
    drain("resume_next");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
